sobel_magnitude: RTL and testbench

//  Streaming 3x3 Sobel edge-magnitude stage.
//  - Input: raster-order 8-bit grayscale pixels.
//  - Output: |Gx|+|Gy| saturated to 8 bits, as grayscale_o/done_o.
//  - Sits directly upstream of grayscale_to_rgb and drives its grayscale_i/done_i.
//  - Two internal line buffers build the 3x3 window on the fly; no frame store.

---
 rtl/sobel_pkg.sv | 26 ++
 rtl/line_buffer.sv | 43 ++++
 rtl/sobel_magnitude.sv | 129 ++++++++++++
 tb/tb_sobel_magnitude.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - widths, saturation limit and kernel coefficients for the Sobel stage
package sobel_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int GRAD_W    = 11;
    localparam int MAG_W     = 12;

    localparam logic [MAG_W-1:0] MAG_MAX = 12'd255;

    localparam logic signed [GRAD_W-1:0] K_EDGE = 11'sd1;
    localparam logic signed [GRAD_W-1:0] K_MID  = 11'sd2;

    // Weighted positive side minus weighted negative side of one Sobel axis.
    function automatic logic signed [GRAD_W-1:0] kernel_diff(
        input logic signed [GRAD_W-1:0] pa0,
        input logic signed [GRAD_W-1:0] pa1,
        input logic signed [GRAD_W-1:0] pa2,
        input logic signed [GRAD_W-1:0] na0,
        input logic signed [GRAD_W-1:0] na1,
        input logic signed [GRAD_W-1:0] na2
    );
        return (K_EDGE * pa0 + K_MID * pa1 + K_EDGE * pa2)
             - (K_EDGE * na0 + K_MID * na1 + K_EDGE * na2);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - fixed-delay line store: dout_o is the pixel written DEPTH enables ago
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    ptr_q;
    logic [AW-1:0]    ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Read-before-write on the same slot gives exactly DEPTH enables of delay.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

    assign dout_o = mem_q[ptr_q];

endmodule

// File: rtl/sobel_magnitude.sv
// rtl/sobel_magnitude.sv - streaming 3x3 Sobel |Gx|+|Gy| with 8-bit saturation
module sobel_magnitude
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] grayscale_i,
    input  logic             done_i,
    output logic [PIX_W-1:0] grayscale_o,
    output logic             done_o,
    output logic             frame_end_o
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_last, row_last;

    logic [PIX_W-1:0] lb0_dout, lb1_dout;
    logic [PIX_W-1:0] win_q [3][3];
    logic             win_vld_q, win_end_q;

    logic signed [GRAD_W-1:0] gx_d, gy_d, gx_q, gy_q;
    logic                     s1_vld_q, s1_end_q;
    logic [GRAD_W-1:0]        abs_gx, abs_gy;
    logic [MAG_W-1:0]         mag;
    logic [PIX_W-1:0]         sat_d, pix_q;
    logic                     done_q, fend_q;

    function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] p);
        return signed'(GRAD_W'(p));
    endfunction

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb0 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (done_i),
        .din_i  (grayscale_i),
        .dout_o (lb0_dout)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (done_i),
        .din_i  (lb0_dout),
        .dout_o (lb1_dout)
    );

    assign col_last = (col_q == CW'(IMG_WIDTH - 1));
    assign row_last = (row_q == RW'(IMG_HEIGHT - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (done_i) begin
            col_d = col_last ? '0 : col_q + CW'(1);
            if (col_last) begin
                row_d = row_last ? '0 : row_q + RW'(1);
            end
        end
    end

    // Window column 2 is the newest; row 0 is the oldest line.
    always_ff @(posedge clk) begin
        if (done_i) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1_dout;
            win_q[1][2] <= lb0_dout;
            win_q[2][2] <= grayscale_i;
        end
    end

    always_comb begin
        gx_d = kernel_diff(ext(win_q[0][2]), ext(win_q[1][2]), ext(win_q[2][2]),
                           ext(win_q[0][0]), ext(win_q[1][0]), ext(win_q[2][0]));
        gy_d = kernel_diff(ext(win_q[2][0]), ext(win_q[2][1]), ext(win_q[2][2]),
                           ext(win_q[0][0]), ext(win_q[0][1]), ext(win_q[0][2]));
        abs_gx = gx_q[GRAD_W-1] ? unsigned'(-gx_q) : unsigned'(gx_q);
        abs_gy = gy_q[GRAD_W-1] ? unsigned'(-gy_q) : unsigned'(gy_q);
        mag    = MAG_W'(abs_gx) + MAG_W'(abs_gy);
        sat_d  = (mag > MAG_MAX) ? PIX_W'(MAG_MAX) : mag[PIX_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q     <= '0;
            row_q     <= '0;
            win_vld_q <= 1'b0;
            win_end_q <= 1'b0;
            gx_q      <= '0;
            gy_q      <= '0;
            s1_vld_q  <= 1'b0;
            s1_end_q  <= 1'b0;
            pix_q     <= '0;
            done_q    <= 1'b0;
            fend_q    <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            // Row/col gating keeps stale line-buffer rows from ever reaching the output.
            win_vld_q <= done_i && (row_q >= RW'(2)) && (col_q >= CW'(2));
            win_end_q <= done_i && row_last && col_last;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            s1_vld_q  <= win_vld_q;
            s1_end_q  <= win_vld_q && win_end_q;
            if (s1_vld_q) begin
                pix_q <= sat_d;
            end
            done_q    <= s1_vld_q;
            fend_q    <= s1_end_q;
        end
    end

    assign grayscale_o = pix_q;
    assign done_o      = done_q;
    assign frame_end_o = fend_q;

endmodule

// File: tb/tb_sobel_magnitude.sv
// tb/tb_sobel_magnitude.sv - directed self-checking bench for sobel_magnitude on a 5x5 image
module tb_sobel_magnitude;

    localparam int W = 5;
    localparam int H = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] grayscale_i = '0;
    logic       done_i = 1'b0;
    logic [7:0] grayscale_o;
    logic       done_o;
    logic       frame_end_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int out_val [$];
    int out_fe  [$];
    int out_cyc [$];
    int exp_cyc [$];

    sobel_magnitude #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .grayscale_i (grayscale_i),
        .done_i      (done_i),
        .grayscale_o (grayscale_o),
        .done_o      (done_o),
        .frame_end_o (frame_end_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && done_o) begin
            out_val.push_back(int'(grayscale_o));
            out_fe.push_back(int'(frame_end_o));
            out_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // mode 0: flat 77, 1: ramp col*10, 2: vertical step at col 2
    function automatic int pix(input int mode, input int c);
        case (mode)
            0:       return 77;
            1:       return c * 10;
            default: return (c < 2) ? 0 : 100;
        endcase
    endfunction

    // Hand-computed magnitude for output k (0..2) within a row of centres.
    function automatic int exp_val(input int mode, input int k);
        case (mode)
            0:       return 0;
            1:       return 80;
            default: return (k < 2) ? 255 : 0;
        endcase
    endfunction

    task automatic send(input int p, input bit v, input bit win);
        @(negedge clk);
        grayscale_i = 8'(p);
        done_i      = v;
        @(posedge clk);
        #1;
        if (v && win) exp_cyc.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            done_i = 1'b0;
        end
    endtask

    task automatic feed_rows(input int mode, input bit gaps, input int r0, input int r1);
        for (int r = r0; r <= r1; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps) send(0, 1'b0, 1'b0);
                send(pix(mode, c), 1'b1, (r >= 2) && (c >= 2));
            end
        end
    endtask

    task automatic clear_q();
        out_val.delete();
        out_fe.delete();
        out_cyc.delete();
        exp_cyc.delete();
    endtask

    task automatic check_frames(input string tag, input int m0, input int m1, input int nf);
        int n;
        chk({tag, "_count"}, out_val.size(), 9 * nf);
        n = (out_val.size() < 9 * nf) ? out_val.size() : 9 * nf;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_val"}, out_val[i], exp_val((i / 9 == 0) ? m0 : m1, i % 3));
            chk({tag, "_fe"}, out_fe[i], (i % 9 == 8) ? 1 : 0);
            if (i < exp_cyc.size()) chk({tag, "_lat"}, out_cyc[i], exp_cyc[i] + 2);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_pix", int'(grayscale_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_fe", int'(frame_end_o), 0);
        @(negedge clk);
        rst = 1'b1;

        clear_q();
        feed_rows(0, 1'b0, 0, H - 1);
        idle(4);
        check_frames("flat", 0, 0, 1);

        clear_q();
        feed_rows(1, 1'b0, 0, H - 1);
        idle(4);
        check_frames("ramp", 1, 1, 1);
        chk("hold_pix", int'(grayscale_o), 80);
        chk("hold_done", int'(done_o), 0);

        clear_q();
        feed_rows(2, 1'b0, 0, H - 1);
        idle(4);
        check_frames("step", 2, 2, 1);

        clear_q();
        feed_rows(1, 1'b1, 0, H - 1);
        idle(4);
        check_frames("gaps", 1, 1, 1);

        clear_q();
        feed_rows(1, 1'b0, 0, 1);
        for (int c = 0; c < 3; c++) send(pix(1, c), 1'b1, 1'b0);
        @(negedge clk);
        done_i = 1'b0;
        rst    = 1'b0;
        #1;
        chk("mid_rst_pix", int'(grayscale_o), 0);
        chk("mid_rst_done", int'(done_o), 0);
        chk("mid_rst_fe", int'(frame_end_o), 0);
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        chk("mid_rst_flush", out_val.size(), 0);
        clear_q();
        feed_rows(0, 1'b0, 0, 1);
        idle(3);
        chk("mid_rst_early", out_val.size(), 0);
        feed_rows(0, 1'b0, 2, H - 1);
        idle(4);
        check_frames("mid_rst", 0, 0, 1);

        clear_q();
        feed_rows(1, 1'b0, 0, H - 1);
        feed_rows(0, 1'b0, 0, H - 1);
        idle(4);
        check_frames("b2b", 1, 0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
